ps2_key_tracker: RTL

//  Consumes scan-code bytes from ps2_keyboard, decodes PS/2 set-2 make/break/E0 sequences and tracks the held key.

---
 rtl/ps2_key_tracker_pkg.sv | 15 +
 rtl/ps2_key_tracker_if.sv | 21 ++
 rtl/ps2_key_tracker_bcd_counter.sv | 43 ++++
 rtl/ps2_key_tracker.sv | 134 +++++++++++++
 4 files changed

// File: rtl/ps2_key_tracker_pkg.sv
// Shared constants and FSM state type for the PS/2 key tracker.
// Holds the set-2 prefix byte values and the byte-handling FSM states.
package ps2_key_tracker_pkg;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_POP   = 2'd1,
        ST_GAP   = 2'd2,
        ST_FLUSH = 2'd3
    } ps2_state_e;

endpackage

// File: rtl/ps2_key_tracker_if.sv
// FIFO-side handshake between ps2_keyboard (master) and the key tracker (slave).
// The tracker pops bytes with an active-low strobe and can clear the keyboard FIFO.
interface ps2_key_tracker_if;

    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       ps2_nextdata_n;
    logic       kbd_clrn;

    modport master (
        output ps2_data, ps2_ready, ps2_overflow,
        input  ps2_nextdata_n, kbd_clrn
    );

    modport slave (
        input  ps2_data, ps2_ready, ps2_overflow,
        output ps2_nextdata_n, kbd_clrn
    );

endinterface

// File: rtl/ps2_key_tracker_bcd_counter.sv
// Registered multi-digit BCD counter, digit 0 in the low nibble.
// Increments on inc; all-9s wraps to all-0s with no carry-out.
module bcd_counter #(
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic                inc,
    output logic [4*DIGITS-1:0] bcd
);

    logic [4*DIGITS-1:0] bcd_next;
    logic [DIGITS-1:0]   carry;

    // Ripple carry: a digit advances only when every lower digit is at 9
    always_comb begin
        carry    = '0;
        bcd_next = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (i == 0) begin
                carry[i] = 1'b1;
            end else begin
                carry[i] = carry[i-1] && (bcd[4*(i-1) +: 4] >= 4'd9);
            end
            if (carry[i]) begin
                if (bcd[4*i +: 4] >= 4'd9) begin
                    bcd_next[4*i +: 4] = 4'd0;
                end else begin
                    bcd_next[4*i +: 4] = bcd[4*i +: 4] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bcd <= '0;
        end else if (inc) begin
            bcd <= bcd_next;
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Decodes PS/2 set-2 make/break/E0 byte streams, tracks the held key,
// counts distinct presses in BCD and maps the result onto seven-segment digits.
module ps2_key_tracker
    import ps2_key_tracker_pkg::*;
#(
    parameter int CNT_DIGITS      = 3,
    parameter int DISP_DIGITS     = 8,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic                      clk,
    input  logic                      clrn,
    ps2_key_tracker_if.slave          ps2,
    output logic [7:0]                key_code,
    output logic                      key_ext,
    output logic                      key_held,
    output logic                      press_pulse,
    output logic                      release_pulse,
    output logic [4*CNT_DIGITS-1:0]   press_cnt,
    output logic [4*DISP_DIGITS-1:0]  disp_data,
    output logic [DISP_DIGITS-1:0]    disp_select
);

    ps2_state_e state, state_next;
    logic       nextdata_n_q, nextdata_n_d;
    logic       kbd_clrn_q, kbd_clrn_d;
    logic       ext_f, ext_d;
    logic       brk_f, brk_d;
    logic [7:0] key_code_d;
    logic       key_ext_d, key_held_d;
    logic       press_d, release_d;
    logic       key_match;

    // Bytes are decoded as they are sampled in IDLE so the pulses appear in the POP cycle
    always_comb begin
        state_next   = state;
        nextdata_n_d = 1'b1;
        kbd_clrn_d   = 1'b1;
        ext_d        = ext_f;
        brk_d        = brk_f;
        key_code_d   = key_code;
        key_ext_d    = key_ext;
        key_held_d   = key_held;
        press_d      = 1'b0;
        release_d    = 1'b0;
        key_match    = key_held && (ps2.ps2_data == key_code) && (ext_f == key_ext);

        case (state)
            ST_IDLE: begin
                if (ps2.ps2_overflow) begin
                    state_next = ST_FLUSH;
                    kbd_clrn_d = 1'b0;
                    ext_d      = 1'b0;
                    brk_d      = 1'b0;
                    key_held_d = 1'b0;
                end else if (ps2.ps2_ready) begin
                    state_next   = ST_POP;
                    nextdata_n_d = 1'b0;
                    if (ps2.ps2_data == PS2_PREFIX_EXT) begin
                        ext_d = 1'b1;
                    end else if (ps2.ps2_data == PS2_PREFIX_BRK) begin
                        brk_d = 1'b1;
                    end else begin
                        ext_d = 1'b0;
                        brk_d = 1'b0;
                        if (brk_f) begin
                            if (key_match) begin
                                key_held_d = 1'b0;
                                release_d  = 1'b1;
                            end
                        end else if (!(key_match && SUPPRESS_REPEAT)) begin
                            key_code_d = ps2.ps2_data;
                            key_ext_d  = ext_f;
                            key_held_d = 1'b1;
                            press_d    = 1'b1;
                        end
                    end
                end
            end
            ST_POP:   state_next = ST_GAP;
            ST_GAP:   state_next = ST_IDLE;
            ST_FLUSH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state         <= ST_IDLE;
            nextdata_n_q  <= 1'b1;
            kbd_clrn_q    <= 1'b0;
            ext_f         <= 1'b0;
            brk_f         <= 1'b0;
            key_code      <= 8'h00;
            key_ext       <= 1'b0;
            key_held      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            nextdata_n_q  <= nextdata_n_d;
            kbd_clrn_q    <= kbd_clrn_d;
            ext_f         <= ext_d;
            brk_f         <= brk_d;
            key_code      <= key_code_d;
            key_ext       <= key_ext_d;
            key_held      <= key_held_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    assign ps2.ps2_nextdata_n = nextdata_n_q;
    assign ps2.kbd_clrn       = kbd_clrn_q;

    bcd_counter #(
        .DIGITS (CNT_DIGITS)
    ) u_press_counter (
        .clk   (clk),
        .clrn  (clrn),
        .inc   (press_d),
        .bcd   (press_cnt)
    );

    // Key code on the two low digits, count above it, everything else blank
    always_comb begin
        disp_data                    = '0;
        disp_data[7:0]               = key_code;
        disp_data[8 +: 4*CNT_DIGITS] = press_cnt;
        disp_select                  = '1;
        disp_select[1:0]             = {2{~key_held}};
        disp_select[2 +: CNT_DIGITS] = '0;
    end

endmodule
